banderas_alu_reg: RTL and testbench
===================================

Name: banderas_alu_reg

Overview:
- Parametrised, registered status-flag unit for the ALU datapath; successor to the combinational 6-bit zero-flag logic.
- Computes ZF, SF, CF and OF from a WIDTH-bit ALU result and registers them one cycle after a valid result.
- Adds a sticky (accumulating) mode for CF/OF and a saturating count of consecutive zero results.
- Sits between the ALU result stage and the control/branch logic.

Parameters:
WIDTH, 6, ALU result width in bits; legal range 2..64.
CNT_W, 4, width of the consecutive-zero counter; it saturates at 2^CNT_W-1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
valid_in  input  1  a result and its side inputs are valid this cycle.
dato  input  WIDTH  ALU result.
carry_in  input  1  carry-out of the adder (borrow-not for subtract).
a_msb  input  1  MSB of operand A.
b_msb  input  1  MSB of operand B as presented to the adder (before inversion).
op_sub  input  1  1 = the operation was a subtract.
sticky  input  1  1 = CF/OF accumulate (OR) instead of overwrite.
flag_clr  input  1  synchronous clear of flags and counter.
ZF  output  1  registered zero flag.
SF  output  1  registered sign flag.
CF  output  1  registered carry flag.
OF  output  1  registered signed-overflow flag.
PF  output  1  registered even-parity flag; tied 0 when the optional feature is off.
valid_out  output  1  flags updated this cycle.
zero_cnt  output  CNT_W  number of consecutive valid zero results.

Behaviour:
- Reset (async, active-high): all outputs go to 0 immediately and stay 0 while rst=1.
- Latency is 1 cycle. valid_in sampled at edge N gives updated flags and valid_out=1 after edge N, for one cycle.
- When valid_in=0: flags and zero_cnt hold, and valid_out=0.
- Combinational next values:
  - zf_n = ~|dato
  - sf_n = dato[WIDTH-1]
  - of_n = (a_msb == (b_msb ^ op_sub)) & (sf_n != a_msb)
  - cf_n = carry_in
- Update on valid_in=1:
  - ZF, SF and PF always overwrite.
  - sticky=0: CF and OF overwrite.
  - sticky=1: CF <= CF | cf_n and OF <= OF | of_n.
- zero_cnt on valid_in=1:
  - zf_n=1: increments, saturating at all ones with no wrap.
  - zf_n=0: loads 0.
- flag_clr=1 (no valid_in): ZF, SF, CF, OF, PF and zero_cnt load 0 on the next edge; valid_out=0.
- flag_clr=1 together with valid_in=1: clear takes priority for the sticky history only.
  - CF and OF load cf_n and of_n directly (as if sticky=0).
  - zero_cnt loads zf_n ? 1 : 0.
  - ZF, SF and PF load the new values.
  - valid_out=1.
- Changing sticky mid-stream is allowed; it takes effect on the next valid_in with no flush.
- Reset asserted mid-stream discards any in-flight update; after deassertion the first valid_in behaves as a fresh start.
- dato wider or narrower than 6 changes only the reduction widths; there is no other width dependence.

Optional Feature:
- Macro: BANDERA_PF_EN.
- Defined: PF <= ~^dato on each valid update (1 when the count of set bits is even); it clears with reset and flag_clr.
- Undefined: PF is constant 0 and no parity logic is generated.

Test Plan:
- Reset: rst=1 mid-operation -> all flags, zero_cnt and valid_out read 0 asynchronously. Release rst and apply dato=0 with valid_in -> next cycle ZF=1, zero_cnt=1, valid_out=1.
- Add overflow, WIDTH=6: a_msb=0, b_msb=0, op_sub=0, dato=6'b100000, carry_in=0 -> OF=1, SF=1, ZF=0, CF=0.
- Subtract sign/zero, WIDTH=8: a_msb=1, b_msb=1, op_sub=1, dato=8'h00, carry_in=1 -> ZF=1, OF=0, CF=1.
- Sticky mode: sticky=1; ops with cf_n=1 then cf_n=0 -> CF stays 1. Then flag_clr with no valid_in -> CF=0 next cycle. Then flag_clr with valid_in and cf_n=1 -> CF=1.
- Saturation: CNT_W=2, five consecutive dato=0 -> zero_cnt reads 1, 2, 3, 3, 3. Then dato=1 -> zero_cnt=0.
- Hold and parity: a gap cycle with valid_in=0 -> flags unchanged, valid_out=0. With BANDERA_PF_EN defined, dato=6'b000011 -> PF=1 and dato=6'b000111 -> PF=0. Without the macro, PF=0 always.

Source files
------------

// File: rtl/banderas_alu_reg_if.sv
// rtl/banderas_alu_reg_if.sv - result/flag bundle between the ALU result stage and the flag register
interface banderas_alu_reg_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
);
  logic             valid_in;
  logic [WIDTH-1:0] dato;
  logic             carry_in;
  logic             a_msb;
  logic             b_msb;
  logic             op_sub;
  logic             sticky;
  logic             flag_clr;
  logic             ZF;
  logic             SF;
  logic             CF;
  logic             OF;
  logic             PF;
  logic             valid_out;
  logic [CNT_W-1:0] zero_cnt;

  modport master (
    output valid_in, dato, carry_in, a_msb, b_msb, op_sub, sticky, flag_clr,
    input  ZF, SF, CF, OF, PF, valid_out, zero_cnt
  );

  modport slave (
    input  valid_in, dato, carry_in, a_msb, b_msb, op_sub, sticky, flag_clr,
    output ZF, SF, CF, OF, PF, valid_out, zero_cnt
  );
endinterface

// File: rtl/banderas_alu_reg.sv
// rtl/banderas_alu_reg.sv - registered ZF/SF/CF/OF with sticky CF/OF and zero-run counter; BANDERA_PF_EN adds parity flag
module banderas_alu_reg #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  banderas_alu_reg_if.slave bus
);
  logic             zf_n, sf_n, cf_n, of_n;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             cf_q, cf_d;
  logic             of_q, of_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign zf_n = ~|bus.dato;
  assign sf_n = bus.dato[WIDTH-1];
  assign cf_n = bus.carry_in;
  // Overflow: operands share a sign (B after subtract inversion) and the result sign differs.
  assign of_n = (bus.a_msb == (bus.b_msb ^ bus.op_sub)) & (sf_n != bus.a_msb);

`ifdef BANDERA_PF_EN
  logic pf_q, pf_d;
  assign bus.PF = pf_q;
`else
  assign bus.PF = 1'b0;
`endif

  always_comb begin
    zf_d    = zf_q;
    sf_d    = sf_q;
    cf_d    = cf_q;
    of_d    = of_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
`ifdef BANDERA_PF_EN
    pf_d    = pf_q;
`endif
    if (bus.valid_in) begin
      valid_d = 1'b1;
      zf_d    = zf_n;
      sf_d    = sf_n;
`ifdef BANDERA_PF_EN
      pf_d    = ~^bus.dato;
`endif
      // A clear alongside a valid result drops only the accumulated history.
      if (bus.sticky && !bus.flag_clr) begin
        cf_d = cf_q | cf_n;
        of_d = of_q | of_n;
      end else begin
        cf_d = cf_n;
        of_d = of_n;
      end
      if (!zf_n) begin
        cnt_d = '0;
      end else if (bus.flag_clr) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (bus.flag_clr) begin
      zf_d  = 1'b0;
      sf_d  = 1'b0;
      cf_d  = 1'b0;
      of_d  = 1'b0;
      cnt_d = '0;
`ifdef BANDERA_PF_EN
      pf_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
`ifdef BANDERA_PF_EN
      pf_q    <= 1'b0;
`endif
    end else begin
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      cf_q    <= cf_d;
      of_q    <= of_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
`ifdef BANDERA_PF_EN
      pf_q    <= pf_d;
`endif
    end
  end

  assign bus.ZF        = zf_q;
  assign bus.SF        = sf_q;
  assign bus.CF        = cf_q;
  assign bus.OF        = of_q;
  assign bus.valid_out = valid_q;
  assign bus.zero_cnt  = cnt_q;
endmodule

// File: tb/tb_banderas_alu_reg.sv
// tb/tb_banderas_alu_reg.sv - directed vectors for banderas_alu_reg at WIDTH=6/CNT_W=2 and WIDTH=8/CNT_W=4
module tb_banderas_alu_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef BANDERA_PF_EN
  localparam logic PF_ON = 1'b1;
`else
  localparam logic PF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  banderas_alu_reg_if #(.WIDTH(6), .CNT_W(2)) if6 ();
  banderas_alu_reg_if #(.WIDTH(8), .CNT_W(4)) if8 ();

  banderas_alu_reg #(.WIDTH(6), .CNT_W(2)) u_dut6 (.clk(clk), .rst(rst), .bus(if6));
  banderas_alu_reg #(.WIDTH(8), .CNT_W(4)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic c, input logic a,
                       input logic b, input logic s, input logic st, input logic clr);
    if6.valid_in = v;   if8.valid_in = v;
    if6.dato = d[5:0];  if8.dato = d;
    if6.carry_in = c;   if8.carry_in = c;
    if6.a_msb = a;      if8.a_msb = a;
    if6.b_msb = b;      if8.b_msb = b;
    if6.op_sub = s;     if8.op_sub = s;
    if6.sticky = st;    if8.sticky = st;
    if6.flag_clr = clr; if8.flag_clr = clr;
  endtask

  task automatic exp6(input string tag, input logic zf, input logic sf, input logic cf,
                      input logic of_e, input logic vo, input logic [1:0] cnt);
    chk({tag, ".zf"}, 64'(if6.ZF), 64'(zf));
    chk({tag, ".sf"}, 64'(if6.SF), 64'(sf));
    chk({tag, ".cf"}, 64'(if6.CF), 64'(cf));
    chk({tag, ".of"}, 64'(if6.OF), 64'(of_e));
    chk({tag, ".vo"}, 64'(if6.valid_out), 64'(vo));
    chk({tag, ".cnt"}, 64'(if6.zero_cnt), 64'(cnt));
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    drive(1'b0, 8'h00, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    exp6("rst", 0, 0, 0, 0, 0, 2'd0);
    chk("rst.pf", 64'(if6.PF), 64'(0));
    chk("rst.cnt8", 64'(if8.zero_cnt), 64'(0));

    rst = 1'b0;
    drive(1'b1, 8'h00, 0, 0, 0, 0, 0, 0);
    cyc();
    exp6("first", 1, 0, 0, 0, 1, 2'd1);
    chk("first.pf", 64'(if6.PF), 64'(PF_ON));

    drive(1'b1, 8'h20, 0, 0, 0, 0, 0, 0);
    cyc();
    exp6("addov", 0, 1, 0, 1, 1, 2'd0);
    chk("addov.pf", 64'(if6.PF), 64'(0));

    drive(1'b0, 8'h3f, 1, 1, 1, 1, 0, 0);
    cyc();
    exp6("hold", 0, 1, 0, 1, 0, 2'd0);

    drive(1'b1, 8'h00, 1, 1, 1, 1, 0, 0);
    cyc();
    chk("sub8.zf", 64'(if8.ZF), 64'(1));
    chk("sub8.sf", 64'(if8.SF), 64'(0));
    chk("sub8.of", 64'(if8.OF), 64'(0));
    chk("sub8.cf", 64'(if8.CF), 64'(1));
    chk("sub8.cnt", 64'(if8.zero_cnt), 64'(1));
    exp6("sub6", 1, 0, 1, 0, 1, 2'd1);

    drive(1'b1, 8'h01, 1, 0, 0, 0, 1, 0);
    cyc();
    exp6("stk_c1", 0, 0, 1, 0, 1, 2'd0);
    drive(1'b1, 8'h01, 0, 0, 0, 0, 1, 0);
    cyc();
    exp6("stk_c0", 0, 0, 1, 0, 1, 2'd0);
    drive(1'b1, 8'h20, 0, 0, 0, 0, 1, 0);
    cyc();
    exp6("stk_o1", 0, 1, 1, 1, 1, 2'd0);
    drive(1'b1, 8'h01, 0, 0, 0, 0, 1, 0);
    cyc();
    exp6("stk_o0", 0, 0, 1, 1, 1, 2'd0);

    drive(1'b0, 8'h00, 1, 0, 0, 0, 1, 1);
    cyc();
    exp6("clr", 0, 0, 0, 0, 0, 2'd0);
    chk("clr.pf", 64'(if6.PF), 64'(0));

    drive(1'b1, 8'h00, 1, 0, 0, 0, 1, 1);
    cyc();
    exp6("clrv1", 1, 0, 1, 0, 1, 2'd1);
    drive(1'b1, 8'h00, 0, 0, 0, 0, 1, 1);
    cyc();
    exp6("clrv0", 1, 0, 0, 0, 1, 2'd1);

    drive(1'b1, 8'h01, 0, 0, 0, 0, 0, 0);
    cyc();
    exp6("sat_pre", 0, 0, 0, 0, 1, 2'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h00, 0, 0, 0, 0, 0, 0);
      cyc();
      chk($sformatf("sat%0d", i), 64'(if6.zero_cnt), 64'(sat_exp[i]));
    end
    drive(1'b1, 8'h01, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("sat_end", 64'(if6.zero_cnt), 64'(0));

    drive(1'b1, 8'h03, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("par3", 64'(if6.PF), 64'(PF_ON));
    drive(1'b1, 8'h07, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("par7", 64'(if6.PF), 64'(0));

    drive(1'b1, 8'h20, 0, 0, 0, 0, 0, 0);
    cyc();
    exp6("pre_arst", 0, 1, 0, 1, 1, 2'd0);
    drive(1'b1, 8'h00, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    exp6("arst", 0, 0, 0, 0, 0, 2'd0);
    cyc();
    exp6("arst_hold", 0, 0, 0, 0, 0, 2'd0);
    rst = 1'b0;
    drive(1'b1, 8'h00, 0, 0, 0, 0, 0, 0);
    cyc();
    exp6("fresh", 1, 0, 0, 0, 1, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
